// File: rtl/sidechan_pkg.sv
// Shared types and default sizing for the ring-oscillator side-channel meters.
package sidechan_pkg;

    // Measurement FSM: IDLE waits for enable, RUN counts gate windows back to back.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } meas_state_t;

    localparam int GATE_CYCLES_DEF = 1_000_000;
    localparam int CNT_W_DEF       = 20;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A rising edge on i_async yields a one-cycle o_rise pulse three clocks later.
module sync_rise_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    // Synchronize the asynchronous input, then register a low-to-high strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated frequency counter: counts divided ring-oscillator edges over a fixed
// window of main_clk cycles, publishes each count with an overflow flag and
// keeps running min/max statistics.
//
// Handshake: meas_valid is a one-cycle pulse with no back-pressure; meas_count
// and meas_ovf are stable from that pulse until the next one (or reset).
// dbg_state exposes the FSM state for observation.
module ring_freq_meter
    import sidechan_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             main_clk,
    input  logic             reset_n,
    input  logic             ring_clk,
    input  logic             enable,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_ovf,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_min,
    output logic [CNT_W-1:0] meas_max,
    output logic             window_led,
    output meas_state_t      dbg_state
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    meas_state_t      r_state;
    meas_state_t      w_next_state;
    logic             w_start;
    logic             w_terminal;
    logic             w_edge;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_acc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic [CNT_W-1:0] r_meas_count;
    logic             r_meas_ovf;
    logic             r_meas_valid;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic             r_led;

    sync_rise_detect u_sync (
        .i_clk   (main_clk),
        .i_rst_n (reset_n),
        .i_async (ring_clk),
        .o_rise  (w_edge)
    );

    // FSM state register.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus window start / window close strobes. Dropping enable
    // in any RUN cycle, including the terminal one, abandons the window.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_terminal   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next_state = RUN;
                    w_start      = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_next_state = IDLE;
                end else if (r_gate_cnt == GATE_LAST) begin
                    w_terminal = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Edge count including this cycle's strobe, saturating and flagging overflow.
    always_comb begin
        w_cnt_next = r_edge_cnt;
        w_ovf_next = r_ovf_acc;
        if (w_edge) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_ovf_next = 1'b1;
            end else begin
                w_cnt_next = r_edge_cnt + CNT_W'(1);
            end
        end
    end

    // Gate and edge counters; cleared on window start and on every window close.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
        end else if (w_start || w_terminal) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
        end else if (r_state == RUN && enable) begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            r_edge_cnt <= w_cnt_next;
            r_ovf_acc  <= w_ovf_next;
        end
    end

    // Publish the closing window's result and toggle the window LED.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            r_meas_count <= '0;
            r_meas_ovf   <= 1'b0;
            r_meas_valid <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_meas_valid <= w_terminal;
            if (w_terminal) begin
                r_meas_count <= w_cnt_next;
                r_meas_ovf   <= w_ovf_next;
                r_led        <= ~r_led;
            end
        end
    end

    // Min/max tracking; a clear coinciding with a sample seeds both with it.
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            r_min <= CNT_MAX;
            r_max <= '0;
        end else if (r_meas_valid) begin
            if (clear_stats) begin
                r_min <= r_meas_count;
                r_max <= r_meas_count;
            end else begin
                if (r_meas_count < r_min) r_min <= r_meas_count;
                if (r_meas_count > r_max) r_max <= r_meas_count;
            end
        end else if (clear_stats) begin
            r_min <= CNT_MAX;
            r_max <= '0;
        end
    end

    assign meas_count = r_meas_count;
    assign meas_ovf   = r_meas_ovf;
    assign meas_valid = r_meas_valid;
    assign meas_min   = r_min;
    assign meas_max   = r_max;
    assign window_led = r_led;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a cycle-indexed stimulus plan is built up front,
// a window-level reference model derives expected results from it, then a
// driver and an independent monitor run concurrently.
module tb_ring_freq_meter;
  import sidechan_pkg::*;

  localparam int G  = 100;
  localparam int CW = 4;
  localparam int N  = 3000;
  localparam logic [CW-1:0] MAXV = {CW{1'b1}};

  // clock / reset block
  logic main_clk = 1'b0;
  logic reset_n = 1'b0;
  logic ring_clk = 1'b0;
  logic enable = 1'b0;
  logic clear_stats = 1'b0;
  logic [CW-1:0] meas_count;
  logic meas_ovf;
  logic meas_valid;
  logic [CW-1:0] meas_min;
  logic [CW-1:0] meas_max;
  logic window_led;
  meas_state_t dbg_state;

  always #5 main_clk = ~main_clk;

  ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) u_dut (
    .main_clk    (main_clk),
    .reset_n     (reset_n),
    .ring_clk    (ring_clk),
    .enable      (enable),
    .clear_stats (clear_stats),
    .meas_count  (meas_count),
    .meas_ovf    (meas_ovf),
    .meas_valid  (meas_valid),
    .meas_min    (meas_min),
    .meas_max    (meas_max),
    .window_led  (window_led),
    .dbg_state   (dbg_state)
  );

  // stimulus plan, one entry per cycle (inputs sampled at the end of that cycle)
  bit en_a[N];
  bit rst_a[N];
  bit clr_a[N];
  bit ring_a[N];
  int per_a[N];

  // reference results, one entry per cycle (outputs visible during that cycle)
  bit run_a[N];
  bit term_a[N];
  bit strobe_a[N];
  logic [CW-1:0] e_cnt[N];
  logic [CW-1:0] e_min[N];
  logic [CW-1:0] e_max[N];
  bit e_ovf[N];
  bit e_valid[N];
  bit e_led[N];

  typedef struct {
    int cyc;
    logic [CW-1:0] cnt;
    logic ovf;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic build_stimulus();
    int plist[9];
    int ph;
    int c;
    int len;
    int p;
    plist = '{4, 5, 6, 8, 10, 12, 16, 20, 25};
    for (int i = 0; i < N; i++) begin
      en_a[i] = 1'b1;
      rst_a[i] = 1'b1;
      clr_a[i] = 1'b0;
      per_a[i] = 10;
    end
    for (int i = 0; i < 5; i++) begin
      rst_a[i] = 1'b0;
      en_a[i] = 1'b0;
      per_a[i] = 0;
    end
    for (int i = 420; i < 760; i++) per_a[i] = 20;
    for (int i = 860; i < 980; i++) per_a[i] = 4;
    for (int i = 980; i < 1170; i++) per_a[i] = 20;
    for (int i = 1170; i < 1300; i++) per_a[i] = 0;
    // abort in the middle of a window, re-enable later
    for (int i = 755; i < 770; i++) en_a[i] = 1'b0;
    // single-cycle reset mid-window, with the ring held quiet around it
    rst_a[1341] = 1'b0;
    for (int i = 1330; i <= 1350; i++) per_a[i] = 0;
    // randomized tail: period changes, enable drops, clear pulses
    c = 1400;
    while (c < N) begin
      len = $urandom_range(60, 220);
      p = plist[$urandom_range(0, 8)];
      for (int i = c; i < c + len && i < N; i++) per_a[i] = p;
      c += len;
    end
    for (int i = 1400; i < N; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        len = $urandom_range(1, 25);
        for (int k = i; k < i + len && k < N; k++) en_a[k] = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) clr_a[i] = 1'b1;
    end
    // square wave from the period plan
    ph = 0;
    for (int i = 0; i < N; i++) begin
      if (per_a[i] == 0) begin
        ring_a[i] = 1'b0;
        ph = 0;
      end else begin
        if (ph >= per_a[i]) ph = 0;
        ring_a[i] = (ph < per_a[i] / 2);
        ph++;
      end
    end
    // isolated pulses; the last one lands its strobe on a terminal cycle (1270)
    ring_a[1200] = 1'b1; ring_a[1201] = 1'b1;
    ring_a[1230] = 1'b1; ring_a[1231] = 1'b1;
    ring_a[1267] = 1'b1; ring_a[1268] = 1'b1;
  endtask

  // Which cycles are in RUN and which close a window follows from enable/reset alone.
  task automatic build_windows();
    int s;
    s = 0;
    run_a[0] = 1'b0;
    term_a[0] = 1'b0;
    for (int c = 1; c < N; c++) begin
      run_a[c] = rst_a[c-1] && en_a[c-1];
      if (run_a[c] && !run_a[c-1]) s = c;
      term_a[c] = run_a[c] && en_a[c] && rst_a[c] && ((c - s) % G == G - 1);
    end
  endtask

  task automatic build_model();
    int n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
    bit ovf;
    bit led;
    // a ring rise driven in cycle k shows up as a counted strobe in cycle k+3
    for (int c = 0; c < N; c++) begin
      strobe_a[c] = 1'b0;
      if (c >= 4)
        strobe_a[c] = ring_a[c-3] && !ring_a[c-4] && rst_a[c-1] && rst_a[c-2] && rst_a[c-3];
    end
    cnt = '0; mn = MAXV; mx = '0; ovf = 1'b0; led = 1'b0;
    e_cnt[0] = '0; e_valid[0] = 1'b0;
    for (int c = 1; c < N; c++) begin
      e_valid[c] = 1'b0;
      if (!rst_a[c-1]) begin
        cnt = '0; mn = MAXV; mx = '0; ovf = 1'b0; led = 1'b0;
      end else begin
        if (e_valid[c-1]) begin
          if (clr_a[c-1]) begin
            mn = e_cnt[c-1];
            mx = e_cnt[c-1];
          end else begin
            if (e_cnt[c-1] < mn) mn = e_cnt[c-1];
            if (e_cnt[c-1] > mx) mx = e_cnt[c-1];
          end
        end else if (clr_a[c-1]) begin
          mn = MAXV;
          mx = '0;
        end
        if (term_a[c-1]) begin
          n = 0;
          for (int k = c - G; k <= c - 1; k++) n += strobe_a[k];
          ovf = (n > int'(MAXV));
          cnt = ovf ? MAXV : CW'(n);
          led = !led;
          e_valid[c] = 1'b1;
          exp_q.push_back('{cyc: c, cnt: cnt, ovf: ovf});
        end
      end
      e_cnt[c] = cnt; e_ovf[c] = ovf; e_min[c] = mn; e_max[c] = mx; e_led[c] = led;
    end
  endtask

  // driver: inputs change 2 time units after each rising edge
  task automatic drive_all();
    for (int c = 1; c < N; c++) begin
      @(posedge main_clk);
      #2;
      reset_n = rst_a[c];
      enable = en_a[c];
      clear_stats = clr_a[c];
      ring_clk = ring_a[c];
    end
  endtask

  // monitor: samples on the falling edge, pops the scoreboard on meas_valid
  task automatic monitor_all();
    exp_t e;
    for (int c = 1; c < N; c++) begin
      @(negedge main_clk);
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid at cycle %0d: got meas_valid=1 expected 0", c);
        end else begin
          e = exp_q.pop_front();
          check("valid_cycle", c, c, e.cyc);
          check("meas_count", c, 32'(meas_count), 32'(e.cnt));
          check("meas_ovf", c, 32'(meas_ovf), 32'(e.ovf));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < c) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_valid at cycle %0d: got no meas_valid expected one at cycle %0d", c, e.cyc);
      end
      check("hold_count", c, 32'(meas_count), 32'(e_cnt[c]));
      check("hold_ovf", c, 32'(meas_ovf), 32'(e_ovf[c]));
      check("meas_min", c, 32'(meas_min), 32'(e_min[c]));
      check("meas_max", c, 32'(meas_max), 32'(e_max[c]));
      check("window_led", c, 32'(window_led), 32'(e_led[c]));
      check("fsm_state", c, 32'(dbg_state), 32'(run_a[c]));
    end
  endtask

  initial begin
    build_stimulus();
    build_windows();
    // clear coinciding with the first all-period-20 window result, and a lone clear later
    clr_a[606] = 1'b1;
    clr_a[650] = 1'b1;
    build_model();
    reset_n = rst_a[0];
    enable = en_a[0];
    clear_stats = clr_a[0];
    ring_clk = ring_a[0];
    fork
      drive_all();
      monitor_all();
    join
    repeat (2) @(negedge main_clk);
    check("queue_drained", N, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Gated frequency counter measuring the divided ring-oscillator clock (the ÷32 `clk_div32` output) against the PLL `main_clk`. It sits directly downstream of the ring-oscillator divider. Each fixed gate window yields one edge count, so supply-droop side-channel effects from the toggling shift register appear as count changes. Results feed LEDs, logging and min/max statistics.

## Interface
- `GATE_CYCLES`, 1_000_000: gate window length in `main_clk` cycles (≥ 16).
- `CNT_W`, 20: width of edge count and statistics.
- `main_clk` in 1: sole clock; all logic on rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `ring_clk` in 1: asynchronous divided ring-oscillator clock. Frequency is required < `main_clk`/4.
- `enable` in 1: level; high runs back-to-back windows.
- `clear_stats` in 1: one-cycle pulse; resets min/max.
- `meas_count` out CNT_W: rising-edge count of the last completed window.
- `meas_ovf` out 1: last window saturated; qualified by `meas_valid`.
- `meas_valid` out 1: one-cycle pulse when `meas_count`/`meas_ovf` update.
- `meas_min` out CNT_W: minimum completed count since reset or clear.
- `meas_max` out CNT_W: maximum completed count since reset or clear.
- `window_led` out 1: toggles on every `meas_valid`.

## Operation
- **Input path:** `ring_clk` passes through a 2-FF synchronizer, then a rising-edge detect register. This produces a one-cycle `edge` strobe.
- **FSM states:** IDLE, RUN.
  - IDLE→RUN on the first cycle `enable`=1. `gate_cnt` and `edge_cnt` clear to 0 in that transition cycle.
  - RUN→IDLE on any cycle `enable`=0. The partial window is discarded: no `meas_valid`, outputs hold.
- **RUN:**
  - `gate_cnt` increments 0..GATE_CYCLES-1.
  - `edge_cnt` increments on `edge` and saturates at 2^CNT_W-1, setting `ovf_acc`.
- **Terminal cycle** (`gate_cnt`=GATE_CYCLES-1):
  - An edge in this cycle is counted into the closing window.
  - The final count and `ovf_acc` are registered to `meas_count`/`meas_ovf`, and `meas_valid` pulses.
  - `gate_cnt`, `edge_cnt` and `ovf_acc` restart at 0 for the next window, with no dead cycle.
- **Statistics:** updated on `meas_valid`: min = min(min, count), max = max(max, count), using unsigned compare.
  - If `clear_stats` coincides with the update, the clear applies first, then the new sample loads: min = max = count.
  - `clear_stats` alone sets min = all-ones and max = 0.
- **Reset values** (`reset_n`=0 at a clock edge): state IDLE; `meas_count`=0; `meas_ovf`=0; `meas_valid`=0; `meas_min`=all-ones; `meas_max`=0; `window_led`=0; synchronizer and edge registers 0. Reset mid-window discards that window.

## Timing
- `ring_clk` rising edge → `edge` strobe: 3 `main_clk` cycles (2 sync stages + detect register).
- Window length is exactly GATE_CYCLES cycles. Windows are back-to-back, with `meas_valid` period = GATE_CYCLES.
- `meas_valid` is asserted the cycle after the terminal cycle. `meas_min`/`meas_max` reflect that sample one cycle after `meas_valid`.
- First `meas_valid` after enable: GATE_CYCLES+1 cycles after the IDLE→RUN cycle.
- Edges arriving during IDLE, or in the 3-cycle pipeline at enable, are counted only if their strobe lands in RUN.

## Structure
- Shared package `sidechan_pkg`:
  - FSM state enum `meas_state_t` {IDLE, RUN}.
  - Default constants `GATE_CYCLES_DEF`, `CNT_W_DEF`.
- Sub-module `sync_rise_detect`: 2-FF synchronizer plus edge detect, reset synchronous active-low. It is reusable for the primary-path divider output.
- The top-level instantiates it once, alongside the FSM, counters and statistics.

## Test plan
- **Basic count:** GATE_CYCLES=100, `ring_clk` period 10 cycles, `enable`=1 → `meas_valid` every 100 cycles with `meas_count`=10; `meas_min`=`meas_max`=10; `window_led` toggles per window.
- **Statistics and clear:** period 10 then 20 for successive windows → counts 10, 5; min=5, max=10. `clear_stats` coinciding with the count-5 `meas_valid` → min=max=5.
- **Abort:** drop `enable` at `gate_cnt`=50 → no `meas_valid`; outputs hold. Re-enable → first valid after exactly 101 cycles.
- **Overflow:** CNT_W=3, period 4, GATE_CYCLES=100 → `meas_count`=7, `meas_ovf`=1. Next window at period 20 → count 5, `meas_ovf`=0.
- **Boundary edge:** place an edge strobe on the terminal cycle → counted in the closing window (count N+1), next window starts at 0.
- **Reset mid-operation:** `reset_n`=0 for 1 cycle at `gate_cnt`=70 → all outputs at reset values next cycle; state IDLE until `enable` is seen.
